// File: rtl/serial_complementer_pkg.sv
// Shared constants and types for the bit-serial complement unit.
package serial_complementer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;

    localparam logic MODE_C1 = 1'b0;
    localparam logic MODE_C2 = 1'b1;

    // 2'd3 is unused; the FSM sends it back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_complementer_if.sv
// Operand/result handshake bundle of the serial complement unit.
interface serial_complementer_if
    import serial_complementer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic             busy;

    // Producer/consumer side: supplies operands and accepts results.
    modport master (
        output in_valid, mode, a, out_ready,
        input  in_ready, out_valid, result, overflow, zero, busy
    );

    // Complement unit side.
    modport slave (
        input  in_valid, mode, a, out_ready,
        output in_ready, out_valid, result, overflow, zero, busy
    );

endinterface

// File: rtl/serial_complementer_bit_cell.sv
// One-bit complement cell: ones' inverts always, two's copies until the first 1.
module comp_bit_cell
    import serial_complementer_pkg::*;
(
    input  logic b,
    input  logic found,
    input  logic mode,
    output logic o,
    output logic found_nxt
);

    logic invert;

    assign invert    = (mode == MODE_C1) | found;
    assign o         = b ^ invert;
    assign found_nxt = found | b;

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial ones'/two's complement unit, LSB first, one bit per cycle.
module serial_complementer
    import serial_complementer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
)
(
    input  logic                  clk,
    input  logic                  reset,
    serial_complementer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               found_q, found_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   src_sr_q, src_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               cell_o;
    logic               cell_found;

    comp_bit_cell u_cell (
        .b         (src_sr_q[0]),
        .found     (found_q),
        .mode      (mode_q),
        .o         (cell_o),
        .found_nxt (cell_found)
    );

    // State, datapath and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            mode_q      <= MODE_C1;
            src_sr_q    <= '0;
            result_q    <= '0;
            ovf_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            mode_q      <= mode_d;
            src_sr_q    <= src_sr_d;
            result_q    <= result_d;
            ovf_pend_q  <= ovf_pend_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, serial datapath and flag capture; status outputs decode the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        mode_d     = mode_q;
        src_sr_d   = src_sr_q;
        result_d   = result_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    src_sr_d   = bus.a;
                    mode_d     = bus.mode;
                    cnt_d      = '0;
                    found_d    = 1'b0;
                    // Most-negative operand has no positive counterpart in C2.
                    ovf_pend_d = (bus.mode == MODE_C2) & bus.a[WIDTH-1]
                                 & ~|bus.a[WIDTH-2:0];
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                result_d = {cell_o, result_q[WIDTH-1:1]};
                src_sr_d = src_sr_q >> 1;
                found_d  = cell_found;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    overflow_d = ovf_pend_q;
                    zero_d     = ~|result_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == SHIFT) || (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_complementer.sv
// Directed bench for serial_complementer (WIDTH=6).
module tb_serial_complementer;
    import serial_complementer_pkg::*;

    localparam int unsigned W = 6;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    serial_complementer_if #(.WIDTH(W)) bus ();

    serial_complementer #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand for one edge; in_ready must be high beforehand.
    task automatic accept(input logic m, input logic [W-1:0] val);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a        = val;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises, bounded.
    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 20);
        check(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        accept(v.mode, v.a);
        wait_done("latency", 6);
        check("result", 32'(bus.result), 32'(v.res));
        check("overflow", 32'(bus.overflow), 32'(v.ovf));
        check("zero", 32'(bus.zero), 32'(v.zero));
        handoff();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{MODE_C2, 6'b000001, 6'b111111, 1'b0, 1'b0};
        vecs[1] = '{MODE_C2, 6'b000011, 6'b111101, 1'b0, 1'b0};
        vecs[2] = '{MODE_C2, 6'b111111, 6'b000001, 1'b0, 1'b0};
        vecs[3] = '{MODE_C2, 6'b101010, 6'b010110, 1'b0, 1'b0};
        vecs[4] = '{MODE_C1, 6'b101010, 6'b010101, 1'b0, 1'b0};
        vecs[5] = '{MODE_C1, 6'b111111, 6'b000000, 1'b0, 1'b1};
        vecs[6] = '{MODE_C2, 6'b100000, 6'b100000, 1'b1, 1'b0};
        vecs[7] = '{MODE_C2, 6'b000000, 6'b000000, 1'b0, 1'b1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = MODE_C1;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        reset = 1'b0;
        tick();

        // Table of directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // Stall in DONE with a competing operand presented during SHIFT.
        accept(MODE_C2, 6'b000011);
        check("busy_in_shift", 32'(bus.busy), 32'd1);
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.mode     = MODE_C1;
        bus.a        = 6'b000001;
        check("in_ready_in_shift", 32'(bus.in_ready), 32'd0);
        wait_done("hold_latency", 4);
        for (int k = 0; k < 3; k++) begin
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_result", 32'(bus.result), 32'(6'b111101));
            check("hold_overflow", 32'(bus.overflow), 32'd0);
            check("hold_zero", 32'(bus.zero), 32'd0);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_handoff_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("pending_accepted", 32'(bus.in_ready), 32'd0);
        wait_done("pending_latency", 6);
        check("pending_result", 32'(bus.result), 32'(6'b111110));
        check("pending_zero", 32'(bus.zero), 32'd0);
        handoff();

        // Asynchronous reset during the third SHIFT cycle.
        accept(MODE_C2, 6'b101010);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        check("arst_zero", 32'(bus.zero), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        v = '{MODE_C2, 6'b000011, 6'b111101, 1'b0, 1'b0};
        run_op(v);

        // Back-to-back with the consumer never stalling.
        bus.out_ready = 1'b1;
        accept(MODE_C2, 6'b000001);
        bus.in_valid = 1'b1;
        bus.mode     = MODE_C1;
        bus.a        = 6'b101010;
        wait_done("b2b_latency_1", 6);
        check("b2b_result_1", 32'(bus.result), 32'(6'b111111));
        tick();
        check("b2b_handoff_out_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_handoff_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_second_accepted", 32'(bus.in_ready), 32'd0);
        wait_done("b2b_latency_2", 6);
        check("b2b_result_2", 32'(bus.result), 32'(6'b010101));
        tick();
        bus.out_ready = 1'b0;
        check("b2b_final_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
